// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART types and constants
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4,
        ST_BREAK  = 3'd5
    } rx_state_t;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_ODD  = 1;
    localparam int PARITY_EVEN = 2;

    localparam int DEFAULT_OVERSAMPLE = 16;

endpackage

// File: rtl/uart_rx_sync.sv
// rtl/uart_rx_sync.sv - two-flop synchroniser for an idle-high async input
module uart_rx_sync (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (!rst) begin
            meta <= 1'b1;
            q    <= 1'b1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - oversampling UART receiver with valid/ready word register
module uart_rx
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = PARITY_NONE,
    parameter int OVERSAMPLE = DEFAULT_OVERSAMPLE
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 baud_tick,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overrun_err,
    output logic                 rx_busy
);

    localparam int OS_W = $clog2(OVERSAMPLE);
    localparam int BC_W = $clog2(DATA_BITS + 1);

    localparam logic [OS_W-1:0] OS_LAST = OS_W'(OVERSAMPLE - 1);
    localparam logic [OS_W-1:0] OS_MID  = OS_W'(OVERSAMPLE / 2 - 1);
    localparam logic [BC_W-1:0] BC_LAST = BC_W'(DATA_BITS - 1);
    localparam logic            ODD_WANT = (PARITY == PARITY_ODD);

    logic rx_s;

    rx_state_t            state, state_n;
    logic [OS_W-1:0]      os_cnt, os_cnt_n;
    logic [BC_W-1:0]      bit_cnt, bit_cnt_n;
    logic [DATA_BITS-1:0] shift_reg, shift_reg_n;
    logic                 par_pend, par_pend_n;
    logic                 commit;

    uart_rx_sync u_sync (
        .clk (clk),
        .rst (rst),
        .d   (rx),
        .q   (rx_s)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= ST_IDLE;
            os_cnt    <= '0;
            bit_cnt   <= '0;
            shift_reg <= '0;
            par_pend  <= 1'b0;
        end else begin
            state     <= state_n;
            os_cnt    <= os_cnt_n;
            bit_cnt   <= bit_cnt_n;
            shift_reg <= shift_reg_n;
            par_pend  <= par_pend_n;
        end
    end

    // Everything holds unless baud_tick; os_cnt wraps naturally at the bit boundary.
    always_comb begin
        state_n     = state;
        os_cnt_n    = os_cnt;
        bit_cnt_n   = bit_cnt;
        shift_reg_n = shift_reg;
        par_pend_n  = par_pend;
        commit      = 1'b0;
        if (baud_tick) begin
            case (state)
                ST_IDLE: begin
                    if (!rx_s) begin
                        state_n  = ST_START;
                        os_cnt_n = '0;
                    end
                end
                ST_START: begin
                    if (os_cnt == OS_MID) begin
                        os_cnt_n = '0;
                        if (!rx_s) begin
                            state_n    = ST_DATA;
                            bit_cnt_n  = '0;
                            par_pend_n = 1'b0;
                        end else begin
                            state_n = ST_IDLE;
                        end
                    end else begin
                        os_cnt_n = os_cnt + OS_W'(1);
                    end
                end
                ST_DATA: begin
                    os_cnt_n = os_cnt + OS_W'(1);
                    if (os_cnt == OS_LAST) begin
                        shift_reg_n = {rx_s, shift_reg[DATA_BITS-1:1]};
                        bit_cnt_n   = bit_cnt + BC_W'(1);
                        if (bit_cnt == BC_LAST) begin
                            state_n = (PARITY != PARITY_NONE) ? ST_PARITY : ST_STOP;
                        end
                    end
                end
                ST_PARITY: begin
                    os_cnt_n = os_cnt + OS_W'(1);
                    if (os_cnt == OS_LAST) begin
                        par_pend_n = ((^shift_reg) ^ rx_s) != ODD_WANT;
                        state_n    = ST_STOP;
                    end
                end
                ST_STOP: begin
                    os_cnt_n = os_cnt + OS_W'(1);
                    if (os_cnt == OS_LAST) begin
                        commit  = 1'b1;
                        state_n = rx_s ? ST_IDLE : ST_BREAK;
                    end
                end
                ST_BREAK: begin
                    if (rx_s) begin
                        state_n = ST_IDLE;
                    end
                end
                default: begin
                    state_n = ST_IDLE;
                end
            endcase
        end
    end

    // Commit takes priority over accept so a word landing on the accept clock is never lost.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            parity_err  <= 1'b0;
            frame_err   <= 1'b0;
            overrun_err <= 1'b0;
        end else if (commit) begin
            rx_data     <= shift_reg;
            rx_valid    <= 1'b1;
            parity_err  <= par_pend;
            frame_err   <= ~rx_s;
            overrun_err <= rx_valid & ~rx_ready;
        end else if (rx_valid && rx_ready) begin
            rx_valid    <= 1'b0;
            parity_err  <= 1'b0;
            frame_err   <= 1'b0;
            overrun_err <= 1'b0;
        end
    end

    assign rx_busy = (state != ST_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - scoreboard bench for uart_rx (8N1 and 8E1 instances)
module tb_uart_rx;
    import uart_pkg::*;

    localparam int OS       = 16;
    localparam int TICK_DIV = 4;
    localparam int BIT_CLKS = OS * TICK_DIV;

    typedef struct packed {
        logic [7:0] data;
        logic       perr;
        logic       ferr;
        logic       oerr;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic baud_tick = 1'b0;
    logic rx1 = 1'b1, rx2 = 1'b1;
    logic ready1 = 1'b1, ready2 = 1'b1;

    logic [7:0] d1, d2;
    logic v1, pe1, fe1, oe1, busy1;
    logic v2, pe2, fe2, oe2, busy2;

    exp_t q1[$];
    exp_t q2[$];
    int checks = 0;
    int errors = 0;

    uart_rx #(.DATA_BITS(8), .PARITY(PARITY_NONE), .OVERSAMPLE(OS)) dut_n (
        .clk(clk), .rst(rst), .baud_tick(baud_tick), .rx(rx1),
        .rx_data(d1), .rx_valid(v1), .rx_ready(ready1),
        .parity_err(pe1), .frame_err(fe1), .overrun_err(oe1), .rx_busy(busy1)
    );

    uart_rx #(.DATA_BITS(8), .PARITY(PARITY_EVEN), .OVERSAMPLE(OS)) dut_e (
        .clk(clk), .rst(rst), .baud_tick(baud_tick), .rx(rx2),
        .rx_data(d2), .rx_valid(v2), .rx_ready(ready2),
        .parity_err(pe2), .frame_err(fe2), .overrun_err(oe2), .rx_busy(busy2)
    );

    always #5 clk = ~clk;

    initial begin
        int c;
        c = 0;
        forever begin
            @(negedge clk);
            baud_tick = (c == TICK_DIV - 1);
            c = (c + 1) % TICK_DIV;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic exp_t mk(input logic [7:0] d, input logic pe, input logic fe, input logic oe);
        exp_t e;
        e.data = d;
        e.perr = pe;
        e.ferr = fe;
        e.oerr = oe;
        return e;
    endfunction

    // Even parity is satisfied when the total count of ones over data and parity bit is even.
    function automatic logic even_violation(input logic [7:0] d, input logic p);
        int ones;
        ones = p;
        for (int i = 0; i < 8; i++) ones += d[i];
        return (ones % 2) != 0;
    endfunction

    // Monitor: samples 1 time unit after the falling edge, once stimulus has settled.
    logic pv1 = 1'b0, pv2 = 1'b0, pt = 1'b0;
    always begin
        exp_t e;
        @(negedge clk);
        #1;
        if (rst) begin
            if (v1 && !pv1) check("latency_n", {31'd0, pt}, 32'd1);
            if (v2 && !pv2) check("latency_e", {31'd0, pt}, 32'd1);
            if (v1 && ready1) begin
                if (q1.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL spurious_n actual=%0h required=none", d1);
                end else begin
                    e = q1.pop_front();
                    check("word_n", {21'd0, d1, pe1, fe1, oe1}, {21'd0, e});
                end
            end
            if (v2 && ready2) begin
                if (q2.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL spurious_e actual=%0h required=none", d2);
                end else begin
                    e = q2.pop_front();
                    check("word_e", {21'd0, d2, pe2, fe2, oe2}, {21'd0, e});
                end
            end
        end
        pv1 = v1;
        pv2 = v2;
        pt  = baud_tick;
    end

    task automatic bit1(input logic b, input int n = 1);
        rx1 = b;
        repeat (n * BIT_CLKS) @(negedge clk);
    endtask

    task automatic bit2(input logic b);
        rx2 = b;
        repeat (BIT_CLKS) @(negedge clk);
    endtask

    task automatic frame1(input logic [7:0] d, input logic stop = 1'b1);
        bit1(1'b0);
        for (int i = 0; i < 8; i++) bit1(d[i]);
        bit1(stop);
    endtask

    task automatic frame2(input logic [7:0] d, input logic p);
        bit2(1'b0);
        for (int i = 0; i < 8; i++) bit2(d[i]);
        bit2(p);
        bit2(1'b1);
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while ((q1.size() != 0 || q2.size() != 0 || v1 || v2) && n < 4000) begin
            @(negedge clk);
            n++;
        end
        check(name, {31'd0, n < 4000}, 32'd1);
    endtask

    initial begin
        logic [7:0] d;
        logic       s, p;

        repeat (3) @(negedge clk);
        #1;
        check("reset_n", {19'd0, d1, v1, pe1, fe1, oe1, busy1}, 32'd0);
        check("reset_e", {19'd0, d2, v2, pe2, fe2, oe2, busy2}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        q1.push_back(mk(8'h5A, 0, 0, 0));
        frame1(8'h5A);
        bit1(1'b1);
        drain("drain_single");

        q1.push_back(mk(8'h00, 0, 0, 0));
        q1.push_back(mk(8'hFF, 0, 0, 0));
        q1.push_back(mk(8'hA5, 0, 0, 0));
        frame1(8'h00);
        frame1(8'hFF);
        frame1(8'hA5);
        bit1(1'b1);
        drain("drain_b2b");

        rx1 = 1'b0;
        repeat (5 * TICK_DIV) @(negedge clk);
        bit1(1'b1, 2);
        #1;
        check("glitch_busy", {31'd0, busy1}, 32'd0);
        check("glitch_valid", {31'd0, v1}, 32'd0);
        q1.push_back(mk(8'h3C, 0, 0, 0));
        frame1(8'h3C);
        bit1(1'b1);
        drain("drain_glitch");

        q2.push_back(mk(8'h07, 1, 0, 0));
        frame2(8'h07, 1'b0);
        q2.push_back(mk(8'h07, 0, 0, 0));
        frame2(8'h07, 1'b1);
        bit2(1'b1);
        drain("drain_parity");

        q1.push_back(mk(8'h00, 0, 1, 0));
        bit1(1'b0, 30);
        bit1(1'b1, 2);
        q1.push_back(mk(8'h81, 0, 0, 0));
        frame1(8'h81);
        bit1(1'b1);
        drain("drain_break");

        ready1 = 1'b0;
        frame1(8'hA1);
        q1.push_back(mk(8'h5C, 0, 0, 1));
        frame1(8'h5C);
        bit1(1'b1);
        #1;
        check("ovr_held", {30'd0, v1, oe1}, 32'd3);
        @(negedge clk);
        ready1 = 1'b1;
        drain("drain_overrun");
        #1;
        check("ovr_clear", {30'd0, v1, oe1}, 32'd0);

        for (int k = 0; k < 30; k++) begin
            d = 8'($urandom);
            s = ($urandom_range(0, 7) != 0);
            q1.push_back(mk(d, 0, ~s, 0));
            frame1(d, s);
            if (!s) bit1(1'b1);
            if ($urandom_range(0, 1) == 1) begin
                rx1 = 1'b1;
                repeat ($urandom_range(1, 100)) @(negedge clk);
            end
        end
        bit1(1'b1);
        drain("drain_rand_n");

        for (int k = 0; k < 10; k++) begin
            d = 8'($urandom);
            p = 1'($urandom);
            q2.push_back(mk(d, even_violation(d, p), 0, 0));
            frame2(d, p);
        end
        bit2(1'b1);
        drain("drain_rand_e");

        ready1 = 1'b0;
        frame1(8'h11);
        bit1(1'b1);
        bit1(1'b0);
        bit1(1'b0);
        bit1(1'b1);
        bit1(1'b1);
        rx1 = 1'b1;
        repeat (BIT_CLKS / 2) @(negedge clk);
        check("pre_reset_busy", {31'd0, busy1}, 32'd1);
        rst = 1'b0;
        @(negedge clk);
        #1;
        check("mid_reset", {19'd0, d1, v1, pe1, fe1, oe1, busy1}, 32'd0);
        rst = 1'b1;
        ready1 = 1'b1;
        bit1(1'b1, 8);
        #1;
        check("post_reset", {30'd0, v1, busy1}, 32'd0);

        check("q_empty_n", q1.size(), 32'd0);
        check("q_empty_e", q2.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
